apb_master: RTL and testbench
=============================

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL: ADDR_WIDTH, 32, address width of cpu_addr/paddr.
REQ-002 SHALL: DATA_WIDTH, 32, data width of all data buses.
REQ-003 SHALL: TIMEOUT, 255, max ACCESS cycles without pready before abort; range 1..65535.
REQ-004 SHALL: pclk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL: presetn  input  1  reset; synchronous, active-low.
REQ-006 SHALL: cpu_req  input  1  CPU request valid.
REQ-007 SHALL: cpu_ready  output  1  request accepted this cycle when cpu_req=1.
REQ-008 SHALL: cpu_addr  input  ADDR_WIDTH  byte address.
REQ-009 SHALL: cpu_wdata  input  DATA_WIDTH  write data.
REQ-010 SHALL: cpu_we  input  1  1=write, 0=read.
REQ-011 SHALL: cpu_stb  input  4  write byte strobes.
REQ-012 SHALL: cpu_done  output  1  one-cycle completion pulse.
REQ-013 SHALL: cpu_rdata  output  DATA_WIDTH  read data, valid with cpu_done.
REQ-014 SHALL: cpu_err  output  1  error flag, valid with cpu_done.
REQ-015 SHALL: paddr  output  ADDR_WIDTH  APB address to interconnect.
REQ-016 SHALL: pdata  output  DATA_WIDTH  APB write data.
REQ-017 SHALL: prdata  input  DATA_WIDTH  APB read data.
REQ-018 SHALL: psel, penable, pwrite  output  1 each  APB control.
REQ-019 SHALL: pstb  output  4  APB write strobes.
REQ-020 SHALL: pready, perr  input  1 each  APB completion/error from interconnect.

Function
REQ-021 SHALL: FSM states IDLE, SETUP, ACCESS, FAULT.
REQ-022 SHALL: cpu_ready=1 only in IDLE; request accepted on edge where cpu_req=1 and cpu_ready=1; addr/wdata/we/stb registered then.
REQ-023 SHALL: accepted request with cpu_addr[1:0]==0 -> SETUP; with cpu_addr[1:0]!=0 -> FAULT, no APB traffic.
REQ-024 SHALL: SETUP (exactly one cycle): psel=1, penable=0; then ACCESS.
REQ-025 SHALL: ACCESS: psel=1, penable=1; held until pready=1 or timeout.
REQ-026 SHALL: paddr, pdata, pwrite, pstb stable from SETUP through last ACCESS cycle; pstb=4'b0000 for reads.
REQ-027 SHALL: ACCESS with pready=1 -> IDLE; next cycle cpu_done=1, cpu_err=perr sampled, cpu_rdata=prdata sampled (reads; writes hold previous cpu_rdata).
REQ-028 SHALL: wait counter clears on SETUP entry, increments each ACCESS cycle with pready=0; on reaching TIMEOUT -> IDLE, psel/penable drop, cpu_done=1, cpu_err=1.
REQ-029 SHALL: pready=1 on the same cycle the counter reaches TIMEOUT counts as normal completion.
REQ-030 SHALL: FAULT lasts one cycle -> IDLE with cpu_done=1, cpu_err=1 next cycle.
REQ-031 SHALL: minimum transfer = 3 cycles accept-to-done (accept, SETUP, ACCESS); next request accepted on the cycle cpu_done is high.
REQ-032 SHALL: psel=0 and penable=0 in IDLE and FAULT; paddr/pdata hold last values.
REQ-033 SHALL: pready/perr ignored outside ACCESS.

Reset
REQ-034 SHALL: presetn=0 at an edge forces IDLE, counter 0, psel=penable=pwrite=0, pstb=0, paddr=pdata=0, cpu_done=cpu_err=0, cpu_rdata=0.
REQ-035 SHALL: reset mid-transfer aborts without cpu_done; psel low from the next edge.

Structure
REQ-036 SHALL: apb_pkg holds state enum, default TIMEOUT, strobe constants (STB_NONE, STB_ALL).
REQ-037 SHALL: single module, no sub-module; wait counter inline, width $clog2(TIMEOUT+1).

Verification
REQ-038 SHALL: write addr 0x100, data 0xDEADBEEF, stb 0xF, pready=1 first ACCESS -> psel 2 cycles, penable 1 cycle, cpu_done cycle 3, cpu_err=0.
REQ-039 SHALL: read addr 0x400, pready after 4 wait cycles, prdata 0x41 -> cpu_rdata=0x41, paddr stable all 6 APB cycles, pstb=0.
REQ-040 SHALL: TIMEOUT=8, pready never -> psel drops after 8 ACCESS cycles, cpu_done with cpu_err=1.
REQ-041 SHALL: read addr 0x102 -> psel never asserted, cpu_done with cpu_err=1 two cycles after accept.
REQ-042 SHALL: write with perr=1 at completion -> cpu_err=1; back-to-back request accepted on the done cycle.
REQ-043 SHALL: presetn low in ACCESS -> psel/penable 0 next edge, no cpu_done, next request completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master.
package apb_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2,
      S_FAULT  = 2'd3
   } apb_state_t;

   localparam int unsigned APB_TIMEOUT_DEFAULT = 255;

   localparam logic [3:0] STB_NONE = 4'b0000;
   localparam logic [3:0] STB_ALL  = 4'b1111;

endpackage

// File: rtl/apb_master.sv
// CPU-to-APB bridge: accepts one request at a time, rejects misaligned
// addresses locally, and aborts APB accesses that exceed TIMEOUT wait cycles.
module apb_master
   import apb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned TIMEOUT    = APB_TIMEOUT_DEFAULT
) (
   input  logic                  pclk,
   input  logic                  presetn,
   input  logic                  cpu_req,
   output logic                  cpu_ready,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   input  logic                  cpu_we,
   input  logic [3:0]            cpu_stb,
   output logic                  cpu_done,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  cpu_err,
   output logic [ADDR_WIDTH-1:0] paddr,
   output logic [DATA_WIDTH-1:0] pdata,
   input  logic [DATA_WIDTH-1:0] prdata,
   output logic                  psel,
   output logic                  penable,
   output logic                  pwrite,
   output logic [3:0]            pstb,
   input  logic                  pready,
   input  logic                  perr
);

   localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
   // Last count value before the counter would reach TIMEOUT.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   apb_state_t       state;
   logic [CNT_W-1:0] wait_cnt;

   // Requests are only taken while idle.
   assign cpu_ready = (state == S_IDLE);

   // Transfer sequencing, APB drive registers and CPU completion reporting.
   always_ff @(posedge pclk) begin
      if (!presetn) begin
         state     <= S_IDLE;
         wait_cnt  <= '0;
         psel      <= 1'b0;
         penable   <= 1'b0;
         pwrite    <= 1'b0;
         pstb      <= STB_NONE;
         paddr     <= '0;
         pdata     <= '0;
         cpu_done  <= 1'b0;
         cpu_err   <= 1'b0;
         cpu_rdata <= '0;
      end else begin
         cpu_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cpu_req) begin
                  if (cpu_addr[1:0] == 2'b00) begin
                     state    <= S_SETUP;
                     paddr    <= cpu_addr;
                     pdata    <= cpu_wdata;
                     pwrite   <= cpu_we;
                     pstb     <= cpu_we ? cpu_stb : STB_NONE;
                     psel     <= 1'b1;
                     penable  <= 1'b0;
                     wait_cnt <= '0;
                  end else begin
                     // Misaligned: APB bus registers are left untouched.
                     state <= S_FAULT;
                  end
               end
            end
            S_SETUP: begin
               state   <= S_ACCESS;
               penable <= 1'b1;
            end
            S_ACCESS: begin
               if (pready) begin
                  // Completion wins even on the cycle the timeout would fire.
                  state    <= S_IDLE;
                  psel     <= 1'b0;
                  penable  <= 1'b0;
                  cpu_done <= 1'b1;
                  cpu_err  <= perr;
                  if (!pwrite) begin
                     cpu_rdata <= prdata;
                  end
               end else if (wait_cnt == CNT_LAST) begin
                  state    <= S_IDLE;
                  psel     <= 1'b0;
                  penable  <= 1'b0;
                  cpu_done <= 1'b1;
                  cpu_err  <= 1'b1;
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            S_FAULT: begin
               state    <= S_IDLE;
               cpu_done <= 1'b1;
               cpu_err  <= 1'b1;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master.sv
// Transaction-level checking bench for apb_master.
module tb_apb_master;

   localparam int unsigned TMO = 8;

   logic        pclk;
   logic        presetn;
   logic        cpu_req;
   logic        cpu_ready;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic        cpu_we;
   logic [3:0]  cpu_stb;
   logic        cpu_done;
   logic [31:0] cpu_rdata;
   logic        cpu_err;
   logic [31:0] paddr;
   logic [31:0] pdata;
   logic [31:0] prdata;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [3:0]  pstb;
   logic        pready;
   logic        perr;

   apb_master #(
      .ADDR_WIDTH(32),
      .DATA_WIDTH(32),
      .TIMEOUT   (TMO)
   ) dut (
      .pclk     (pclk),
      .presetn  (presetn),
      .cpu_req  (cpu_req),
      .cpu_ready(cpu_ready),
      .cpu_addr (cpu_addr),
      .cpu_wdata(cpu_wdata),
      .cpu_we   (cpu_we),
      .cpu_stb  (cpu_stb),
      .cpu_done (cpu_done),
      .cpu_rdata(cpu_rdata),
      .cpu_err  (cpu_err),
      .paddr    (paddr),
      .pdata    (pdata),
      .prdata   (prdata),
      .psel     (psel),
      .penable  (penable),
      .pwrite   (pwrite),
      .pstb     (pstb),
      .pready   (pready),
      .perr     (perr)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   int n_checks = 0;
   int n_err    = 0;

   // Model of the externally visible bus/CPU registers.
   logic [31:0] m_paddr, m_pdata, m_rdata;
   logic        m_pwrite;
   logic [3:0]  m_pstb;

   // Expected outputs for the cycle following the next rising edge.
   logic        e_ready, e_done, e_err, e_psel, e_pen, e_pwrite;
   logic [31:0] e_paddr, e_pdata, e_rdata;
   logic [3:0]  e_pstb;
   bit          e_chk_ctl, e_chk_err;
   bit          chk_en = 1'b0;

   // Observations used by the literal checks.
   int          cyc = 0;
   int          n_psel, n_pen, done_cyc;
   logic        done_err;
   logic [31:0] done_rdata;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_paddr  = '0;
      m_pdata  = '0;
      m_rdata  = '0;
      m_pwrite = 1'b0;
      m_pstb   = 4'h0;
   endtask

   task automatic set_exp(input bit rdy, input bit done, input bit err,
                          input bit sel, input bit en, input bit chk_all);
      e_ready   = rdy;
      e_done    = done;
      e_err     = err;
      e_psel    = sel;
      e_pen     = en;
      e_paddr   = m_paddr;
      e_pdata   = m_pdata;
      e_pwrite  = m_pwrite;
      e_pstb    = m_pstb;
      e_rdata   = m_rdata;
      e_chk_ctl = sel || chk_all;
      e_chk_err = done || chk_all;
   endtask

   task automatic clear_obs();
      n_psel   = 0;
      n_pen    = 0;
      done_cyc = -1;
   endtask

   // Single compare process: every cycle, DUT outputs against the model.
   always @(posedge pclk) begin
      cyc++;
      #2;
      if (chk_en) begin
         chk("cpu_ready", 32'(cpu_ready), 32'(e_ready));
         chk("cpu_done",  32'(cpu_done),  32'(e_done));
         chk("psel",      32'(psel),      32'(e_psel));
         chk("penable",   32'(penable),   32'(e_pen));
         chk("paddr",     paddr,          e_paddr);
         chk("pdata",     pdata,          e_pdata);
         chk("cpu_rdata", cpu_rdata,      e_rdata);
         if (e_chk_ctl) begin
            chk("pwrite", 32'(pwrite), 32'(e_pwrite));
            chk("pstb",   32'(pstb),   32'(e_pstb));
         end
         if (e_chk_err) chk("cpu_err", 32'(cpu_err), 32'(e_err));
         if (psel)    n_psel++;
         if (penable) n_pen++;
         if (cpu_done) begin
            done_cyc   = cyc;
            done_err   = cpu_err;
            done_rdata = cpu_rdata;
         end
      end
   end

   task automatic idle_cycle();
      presetn   = 1'b1;
      cpu_req   = 1'b0;
      cpu_addr  = $urandom;
      cpu_wdata = $urandom;
      cpu_we    = 1'($urandom);
      cpu_stb   = 4'($urandom);
      pready    = 1'($urandom);
      perr      = 1'($urandom);
      prdata    = $urandom;
      set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge pclk);
   endtask

   // Drives one request starting in an idle cycle. waits = ACCESS cycles with
   // pready low before the completing one; waits >= TMO means a timeout.
   // rst_at >= 0 pulls presetn low in that cycle of the transfer.
   task automatic run_txn(input logic [31:0] a, input logic [31:0] wd, input logic we,
                          input logic [3:0] stb, input int waits, input logic perr_v,
                          input logic [31:0] rd, input int rst_at, output int acc);
      bit fault, tmo, hit, acc_cycle;
      int len, last, k;
      fault = (a[1:0] != 2'b00);
      tmo   = !fault && (waits >= int'(TMO));
      len   = fault ? 0 : ((waits + 1 < int'(TMO)) ? waits + 1 : int'(TMO));
      last  = fault ? 1 : 1 + len;
      acc   = cyc;
      for (int j = 0; j <= last; j++) begin
         presetn = 1'b1;
         if (j == 0) begin
            cpu_req   = 1'b1;
            cpu_addr  = a;
            cpu_wdata = wd;
            cpu_we    = we;
            cpu_stb   = stb;
         end else begin
            cpu_req   = 1'($urandom);
            cpu_addr  = $urandom;
            cpu_wdata = $urandom;
            cpu_we    = 1'($urandom);
            cpu_stb   = 4'($urandom);
         end
         acc_cycle = !fault && (j >= 2);
         hit       = acc_cycle && !tmo && (j == waits + 2);
         pready    = acc_cycle ? hit : 1'($urandom);
         perr      = hit ? perr_v : 1'($urandom);
         prdata    = hit ? rd : $urandom;
         if (j == rst_at) begin
            presetn = 1'b0;
            cpu_req = 1'b0;
            model_reset();
            set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            @(negedge pclk);
            return;
         end
         k = j + 1;
         if (fault) begin
            if (k == 1) set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            else        set_exp(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
         end else begin
            if (j == 0) begin
               m_paddr  = a;
               m_pdata  = wd;
               m_pwrite = we;
               m_pstb   = we ? stb : 4'h0;
            end
            if (k <= 1 + len) begin
               set_exp(1'b0, 1'b0, 1'b0, 1'b1, k >= 2, 1'b0);
            end else begin
               if (!tmo && !we) m_rdata = rd;
               set_exp(1'b1, 1'b1, tmo ? 1'b1 : perr_v, 1'b0, 1'b0, 1'b0);
            end
         end
         @(negedge pclk);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got running expected done");
      $fatal(1);
   end

   initial begin
      int acc, acc2, gap, waits, rsel;
      logic [31:0] a;
      presetn   = 1'b0;
      cpu_req   = 1'b0;
      cpu_addr  = '0;
      cpu_wdata = '0;
      cpu_we    = 1'b0;
      cpu_stb   = 4'h0;
      prdata    = '0;
      pready    = 1'b0;
      perr      = 1'b0;
      model_reset();
      set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      clear_obs();
      @(negedge pclk);
      chk_en = 1'b1;
      @(negedge pclk);
      idle_cycle();

      // Zero-wait write.
      clear_obs();
      run_txn(32'h100, 32'hDEADBEEF, 1'b1, 4'hF, 0, 1'b0, 32'h0, -1, acc);
      chk("w0_psel_cycles", 32'(n_psel), 32'd2);
      chk("w0_penable_cycles", 32'(n_pen), 32'd1);
      chk("w0_done_latency", 32'(done_cyc - acc), 32'd3);
      chk("w0_err", 32'(done_err), 32'd0);
      chk("w0_rdata_hold", done_rdata, 32'h0);
      idle_cycle();

      // Read with four wait cycles.
      clear_obs();
      run_txn(32'h400, 32'h12345678, 1'b0, 4'hA, 4, 1'b0, 32'h41, -1, acc);
      chk("r4_psel_cycles", 32'(n_psel), 32'd6);
      chk("r4_penable_cycles", 32'(n_pen), 32'd5);
      chk("r4_rdata", done_rdata, 32'h41);
      chk("r4_done_latency", 32'(done_cyc - acc), 32'd7);
      idle_cycle();

      // pready never arrives.
      clear_obs();
      run_txn(32'h800, 32'h0, 1'b0, 4'h0, 1000, 1'b0, 32'h0, -1, acc);
      chk("tmo_psel_cycles", 32'(n_psel), 32'd9);
      chk("tmo_penable_cycles", 32'(n_pen), 32'd8);
      chk("tmo_err", 32'(done_err), 32'd1);
      chk("tmo_rdata_hold", done_rdata, 32'h41);
      idle_cycle();

      // pready on the very cycle the counter would expire.
      clear_obs();
      run_txn(32'h804, 32'h0, 1'b0, 4'h0, 7, 1'b0, 32'hCAFE0007, -1, acc);
      chk("edge_psel_cycles", 32'(n_psel), 32'd9);
      chk("edge_err", 32'(done_err), 32'd0);
      chk("edge_rdata", done_rdata, 32'hCAFE0007);
      idle_cycle();

      // Misaligned read.
      clear_obs();
      run_txn(32'h102, 32'h0, 1'b0, 4'h0, 0, 1'b0, 32'h0, -1, acc);
      chk("mis_psel_cycles", 32'(n_psel), 32'd0);
      chk("mis_done_latency", 32'(done_cyc - acc), 32'd2);
      chk("mis_err", 32'(done_err), 32'd1);
      idle_cycle();

      // Slave error, then a request accepted on the done cycle.
      clear_obs();
      run_txn(32'h200, 32'h55AA55AA, 1'b1, 4'h3, 2, 1'b1, 32'h0, -1, acc);
      chk("perr_err", 32'(done_err), 32'd1);
      clear_obs();
      run_txn(32'h204, 32'h0, 1'b0, 4'h0, 0, 1'b0, 32'h0BADF00D, -1, acc2);
      chk("b2b_done_latency", 32'(done_cyc - acc2), 32'd3);
      chk("b2b_err", 32'(done_err), 32'd0);
      idle_cycle();

      // Reset during ACCESS, then a normal transfer.
      clear_obs();
      run_txn(32'h300, 32'h11112222, 1'b1, 4'hF, 5, 1'b0, 32'h0, 3, acc);
      idle_cycle();
      idle_cycle();
      chk("rst_no_done", 32'(done_cyc), 32'hFFFF_FFFF);
      clear_obs();
      run_txn(32'h304, 32'h0, 1'b0, 4'h0, 1, 1'b0, 32'h77, -1, acc);
      chk("post_rst_rdata", done_rdata, 32'h77);
      chk("post_rst_err", 32'(done_err), 32'd0);

      // Randomized traffic.
      for (int t = 0; t < 300; t++) begin
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) idle_cycle();
         a = $urandom;
         if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
         waits = $urandom_range(0, 10);
         rsel  = ($urandom_range(0, 24) == 0) ? int'($urandom_range(0, 4)) : -1;
         run_txn(a, $urandom, 1'($urandom), 4'($urandom), waits, 1'($urandom),
                 $urandom, rsel, acc);
      end
      idle_cycle();
      idle_cycle();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
